// File: rtl/booth_div.sv
// -----------------------------------------------------------------------------
// booth_div
//   Sequential signed radix-2 restoring divider, one quotient bit per clock.
//   Divides two's-complement A by B and returns a quotient truncated toward
//   zero plus a remainder carrying the sign of A, so that A = Q*B + R.
//   The en/done handshake matches booth_mult, so one controller can drive both.
//
//   Latency: done rises width+1 edges after the start edge.
//
// Parameters
//   width     operand / result width in bits (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   en        request level; hold high until done is seen, drop to release
//   A         signed dividend, sampled on the start edge only
//   B         signed divisor, sampled on the start edge only
//   done      result valid (registered)
//   Q         signed quotient (registered, held until the next result)
//   R         signed remainder (registered, held until the next result)
//   div_zero  divide-by-zero flag, present only when DIV_ZERO_DET_EN is defined
//
// Configuration
//   DIV_ZERO_DET_EN  when defined, adds div_zero and a one-edge fast path
//                    for B = 0. When undefined, B = 0 takes the full
//                    iteration sequence and yields the same Q/R.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_div #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [width-1:0] A,
    input  logic [width-1:0] B,
    output logic             done,
    output logic [width-1:0] Q,
    output logic [width-1:0] R
`ifdef DIV_ZERO_DET_EN
    ,
    output logic             div_zero
`endif
);

    localparam int CW = (width > 2) ? $clog2(width) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [width-1:0] quo_q, quo_d;     // dividend magnitude, shifted into quotient
    logic [width-1:0] dvs_q, dvs_d;     // divisor magnitude
    logic [width-1:0] rem_q, rem_d;     // partial remainder (always < divisor)
    logic             sign_a_q, sign_a_d;
    logic             neg_quo_q, neg_quo_d;
    logic             done_q, done_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] r_q, r_d;
`ifdef DIV_ZERO_DET_EN
    logic             dz_q, dz_d;
`endif

    // Magnitudes are held unsigned, so |-2^(width-1)| = 2^(width-1) fits.
    logic [width-1:0] abs_a, abs_b;
    assign abs_a = A[width-1] ? (~A + 1'b1) : A;
    assign abs_b = B[width-1] ? (~B + 1'b1) : B;

    // Shift {rem,quo} left by one and trial-subtract the divisor. The shifted
    // value is below 2^width (rem < divisor, or rem holds only the leading
    // dividend bits when the divisor is 0), so width+1 bits carry the sign.
    logic [width:0] shifted, trial;
    assign shifted = {rem_q, quo_q[width-1]};
    assign trial   = shifted - {1'b0, dvs_q};

    always_comb begin
        // NOTE: every next-state value defaults to its current value first, so
        // no path through the case statement can leave a latch behind.
        state_d   = state_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        sign_a_d  = sign_a_q;
        neg_quo_d = neg_quo_q;
        done_d    = done_q;
        q_d       = q_q;
        r_d       = r_q;
`ifdef DIV_ZERO_DET_EN
        dz_d      = dz_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (en) begin
                    quo_d    = abs_a;
                    dvs_d    = abs_b;
                    rem_d    = '0;
                    cnt_d    = '0;
                    sign_a_d = A[width-1];
                    // A zero divisor has no sign; leaving the all-ones
                    // quotient un-negated keeps Q = -1 for every A.
                    neg_quo_d = (A[width-1] ^ B[width-1]) & (B != '0);
                    state_d   = S_CALC;
`ifdef DIV_ZERO_DET_EN
                    if (B == '0) state_d = S_FIX;
`endif
                end
            end

            S_CALC: begin
                if (!trial[width]) begin
                    rem_d = trial[width-1:0];
                    quo_d = {quo_q[width-2:0], 1'b1};
                end else begin
                    rem_d = shifted[width-1:0];
                    quo_d = {quo_q[width-2:0], 1'b0};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(width - 1)) state_d = S_FIX;
            end

            S_FIX: begin
                q_d     = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
                r_d     = sign_a_q  ? (~rem_q + 1'b1) : rem_q;
`ifdef DIV_ZERO_DET_EN
                // Fast path skipped the iterations: quo still holds |A|.
                dz_d = (dvs_q == '0);
                if (dvs_q == '0) begin
                    q_d = '1;
                    r_d = sign_a_q ? (~quo_q + 1'b1) : quo_q;
                end
`endif
                done_d  = 1'b1;
                state_d = S_DONE;
            end

            default: begin  // S_DONE
                if (!en) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // NOTE: working registers are reset along with the visible state; none of
    // them is a memory array, so the reset costs nothing and keeps X out of
    // simulation after a mid-operation abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            sign_a_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            done_q    <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
`ifdef DIV_ZERO_DET_EN
            dz_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            sign_a_q  <= sign_a_d;
            neg_quo_q <= neg_quo_d;
            done_q    <= done_d;
            q_q       <= q_d;
            r_q       <= r_d;
`ifdef DIV_ZERO_DET_EN
            dz_q      <= dz_d;
`endif
        end
    end

    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
`ifdef DIV_ZERO_DET_EN
    assign div_zero = dz_q;
`endif

endmodule

// File: tb/tb_booth_div.sv
// -----------------------------------------------------------------------------
// tb_booth_div
//   Scoreboard bench for booth_div (width = 8). Stimulus pushes the expected
//   {Q, R, div_zero} into a queue; an independent monitor pops and compares
//   on every rising edge of done. Handshake timing, reset behaviour and the
//   hold of Q/R are checked directly by the stimulus process.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_booth_div;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         done;
    logic [W-1:0] Q;
    logic [W-1:0] R;
`ifdef DIV_ZERO_DET_EN
    logic         div_zero;
    localparam bit DZ_EN = 1'b1;
`else
    logic         div_zero;
    localparam bit DZ_EN = 1'b0;
    assign div_zero = 1'b0;
`endif

    booth_div #(.width(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .A        (A),
        .B        (B),
        .done     (done),
        .Q        (Q),
        .R        (R)
`ifdef DIV_ZERO_DET_EN
        ,
        .div_zero (div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           a;
        int           b;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare on every rising edge of done, sampled at negedge.
    logic done_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            done_prev = 1'b0;
        end else begin
            if (done && !done_prev) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if ($signed(Q) != $signed(e.q) || $signed(R) != $signed(e.r))
                        $display("  operands A=%0d B=%0d", e.a, e.b);
                    check("Q", int'($signed(Q)), int'($signed(e.q)));
                    check("R", int'($signed(R)), int'($signed(e.r)));
                    if (DZ_EN) check("div_zero", int'(div_zero), int'(e.dz));
                end
            end
            done_prev = done;
        end
    end

    // One full handshake. Expected latency: width+1 edges, or 1 edge on the
    // zero-divisor fast path. A/B are scrambled mid-operation to show they are
    // ignored; drop_early releases en during the iterations.
    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input bit chk_lat, input bit drop_early);
        exp_t e;
        int   cyc;
        bit   fast;
        fast = DZ_EN && (b == 0);
        e.q  = W'(eq);
        e.r  = W'(er);
        e.dz = (b == 0);
        e.a  = a;
        e.b  = b;
        sb_q.push_back(e);
        @(negedge clk);
        A   = W'(a);
        B   = W'(b);
        en  = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 2 && !done) begin
                A = W'($urandom);
                B = W'($urandom);
            end
            if (drop_early && cyc == 3) en = 1'b0;
        end while (!done && cyc < 40);
        if (!done) check("done_timeout", 0, 1);
        if (chk_lat) check("latency", cyc - 1, fast ? 1 : W + 1);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("done_fall", int'(done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        A     = '0;
        B     = '0;
        #22;
        check("rst_done", int'(done), 0);
        check("rst_Q", int'(Q), 0);
        check("rst_R", int'(R), 0);
        check("rst_div_zero", int'(div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors, hand-computed.
        run_op( 100,    7,   14,   2, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("hold_Q", int'($signed(Q)), 14);
        check("hold_R", int'($signed(R)), 2);
        run_op(-100,    7,  -14,  -2, 1'b1, 1'b0);
        run_op( 100,   -7,  -14,   2, 1'b0, 1'b0);
        run_op(-100,   -7,   14,  -2, 1'b0, 1'b0);
        run_op(-128,   -1, -128,   0, 1'b0, 1'b0);
        run_op(-128,    1, -128,   0, 1'b0, 1'b0);
        run_op( 127, -128,    0, 127, 1'b0, 1'b0);
        run_op(   5,    0,   -1,   5, 1'b1, 1'b0);
        run_op(  -5,    0,   -1,  -5, 1'b1, 1'b0);
        run_op(  -7,    2,   -3,  -1, 1'b1, 1'b1);   // en dropped mid-calc

        // Reset mid-iteration: outputs clear at once, nothing is reported.
        @(negedge clk);
        A  = W'(100);
        B  = W'(7);
        en = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        check("midrst_done", int'(done), 0);
        check("midrst_Q", int'(Q), 0);
        check("midrst_R", int'(R), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        run_op(9, 3, 3, 0, 1'b1, 1'b0);

        // Strided sweep against Verilog signed / and %.
        begin
            int bl[12] = '{-128, -77, -13, -3, -2, -1, 1, 2, 3, 9, 64, 127};
            for (int a = -128; a <= 127; a += 7) begin
                foreach (bl[j]) begin
                    if (!(a == -128 && bl[j] == -1))
                        run_op(a, bl[j], a / bl[j], a % bl[j], 1'b0, 1'b0);
                end
            end
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
